// File: rtl/binary_step_counter_if.sv
// Signal bundle between the pushbutton/load sources and the binary step counter.
// The master side drives buttons and load; the slave side (the counter) returns the count and strobes.
interface binary_step_counter_if #(
   parameter int WIDTH = 4
);
   logic             btn_up_n;
   logic             btn_down_n;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             auto_en;
   logic [WIDTH-1:0] binary_out;
   logic             step_pulse;
   logic             wrap;

   modport master (
      output btn_up_n, btn_down_n, load, load_value, auto_en,
      input  binary_out, step_pulse, wrap
   );

   modport slave (
      input  btn_up_n, btn_down_n, load, load_value, auto_en,
      output binary_out, step_pulse, wrap
   );
endinterface

// File: rtl/binary_step_counter.sv
// Debounced up/down pushbutton counter with synchronous load feeding the binary-to-Gray path.
// Optional macro AUTO_STEP_EN adds a periodic auto-increment timer gated by auto_en.
module binary_step_counter_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press_p2
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_PENDING,
      PRESSED,
      RELEASE_PENDING
   } db_state_t;

   logic             sync1_p0;
   logic             sync2_p1;
   db_state_t        state;
   logic [CNT_W-1:0] cnt;

   // Stage p0/p1: two-flop synchronizer; stage p2: debounce FSM with a one-cycle press event.
   // The pending states accept the level on the cycle where cnt+1 would reach DEBOUNCE_CYCLES-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_p0 <= 1'b1;
         sync2_p1 <= 1'b1;
         state    <= RELEASED;
         cnt      <= '0;
         press_p2 <= 1'b0;
      end else begin
         sync1_p0 <= btn_n;
         sync2_p1 <= sync1_p0;
         press_p2 <= 1'b0;
         case (state)
            RELEASED: begin
               if (!sync2_p1) begin
                  state <= PRESS_PENDING;
                  cnt   <= CNT_ONE;
               end
            end
            PRESS_PENDING: begin
               if (sync2_p1) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else if (cnt >= CNT_LAST) begin
                  state    <= PRESSED;
                  cnt      <= '0;
                  press_p2 <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            PRESSED: begin
               if (sync2_p1) begin
                  state <= RELEASE_PENDING;
                  cnt   <= CNT_ONE;
               end
            end
            RELEASE_PENDING: begin
               if (!sync2_p1) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt >= CNT_LAST) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end
endmodule

module binary_step_counter #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int AUTO_PERIOD     = 50000000
) (
   input logic                  clk,
   input logic                  rst,
   binary_step_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic             press_up_p2;
   logic             press_dn_p2;
   logic             tick_p2;
   logic [WIDTH-1:0] count_p3;
   logic             step_p3;
   logic             wrap_p3;

   binary_step_counter_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk      (clk),
      .rst      (rst),
      .btn_n    (bus.btn_up_n),
      .press_p2 (press_up_p2)
   );

   binary_step_counter_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
      .clk      (clk),
      .rst      (rst),
      .btn_n    (bus.btn_down_n),
      .press_p2 (press_dn_p2)
   );

`ifdef AUTO_STEP_EN
   localparam int TMR_W = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_PERIOD - 1);

   logic [TMR_W-1:0] timer;

   // Stage p2: auto tick registered alongside the button events; timer restarts whenever auto_en drops.
   always_ff @(posedge clk) begin
      if (rst || !bus.auto_en) begin
         timer   <= '0;
         tick_p2 <= 1'b0;
      end else if (timer == TMR_LAST) begin
         timer   <= '0;
         tick_p2 <= 1'b1;
      end else begin
         timer   <= timer + TMR_ONE;
         tick_p2 <= 1'b0;
      end
   end
`else
   assign tick_p2 = 1'b0;
`endif

   // Stage p3: one action per cycle; lower-priority actions in the same cycle are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_p3 <= '0;
         step_p3  <= 1'b0;
         wrap_p3  <= 1'b0;
      end else begin
         step_p3 <= 1'b0;
         wrap_p3 <= 1'b0;
         if (bus.load) begin
            count_p3 <= bus.load_value;
            step_p3  <= 1'b1;
         end else if (press_up_p2 && press_dn_p2) begin
            count_p3 <= count_p3;
         end else if (press_up_p2) begin
            count_p3 <= count_p3 + ONE;
            step_p3  <= 1'b1;
            wrap_p3  <= (count_p3 == CNT_MAX);
         end else if (press_dn_p2) begin
            count_p3 <= count_p3 - ONE;
            step_p3  <= 1'b1;
            wrap_p3  <= (count_p3 == '0);
         end else if (tick_p2) begin
            count_p3 <= count_p3 + ONE;
            step_p3  <= 1'b1;
            wrap_p3  <= (count_p3 == CNT_MAX);
         end
      end
   end

   assign bus.binary_out = count_p3;
   assign bus.step_pulse = step_p3;
   assign bus.wrap       = wrap_p3;
endmodule
